// File: rtl/enemy_pixel_pipe.sv
// Enemy sprite pixel pipeline: sprite ROM addressing, two-stage transparency-aware
// palette output, and the alive / squished / gone death sequence with stomp pulse.
module enemy_pixel_pipe #(
   parameter int SQUISH_FRAMES = 30,
   parameter int BLINK_FRAMES  = 8
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       is_enemy,
   input  logic [8:0] enemy_address,
   input  logic       enemy_walk_count,
   input  logic       enemy_health,
   output logic [9:0] rom_addr,
   input  logic [3:0] rom_data,
   output logic       enemy_pixel_valid,
   output logic [3:0] enemy_color_idx,
   output logic       stomp_pulse,
   output logic [1:0] enemy_state
);

   typedef enum logic [1:0] {
      ALIVE  = 2'b00,
      SQUISH = 2'b01,
      GONE   = 2'b10
   } state_t;

   localparam logic [5:0] SQUISH_LOAD = 6'(SQUISH_FRAMES);
   localparam logic [5:0] BLINK_LIM   = 6'(BLINK_FRAMES);

   state_t     r_state, w_stateNext;
   logic [5:0] r_count, w_countNext;
   logic       r_blink, w_blinkNext;
   logic       r_stomp, w_stompNext;
   logic       r_fSync1, r_fSync2, r_fPrev;
   logic       r_visD1;
   logic       r_pixelValid;
   logic [3:0] r_colorIdx;

   logic       w_frameTick;
   logic       w_respawn;
   logic       w_stomped;
   logic       w_visible;
   logic [1:0] w_frameSel;
   logic       w_opaque;
   logic       w_unusedAddrMsb;

   assign w_unusedAddrMsb = enemy_address[8];

   assign w_frameTick = r_fSync2 & ~r_fPrev;
   assign w_respawn   = is_enemy & enemy_health;
   assign w_stomped   = is_enemy & ~enemy_health;

   assign w_frameSel  = (r_state == ALIVE) ? {1'b0, enemy_walk_count} : 2'b10;
   assign rom_addr    = {w_frameSel, enemy_address[7:0]};

   // The blink phase flips as the counter steps into the tail, so the first tail frame is dark.
   assign w_visible = (r_state == ALIVE) |
                      ((r_state == SQUISH) & ((r_count > BLINK_LIM) | r_blink));

   assign w_opaque = (rom_data != 4'd0);

   always_comb begin
      w_stateNext = r_state;
      w_countNext = r_count;
      w_blinkNext = r_blink;
      w_stompNext = 1'b0;
      case (r_state)
         ALIVE: begin
            if (w_stomped) begin
               w_stateNext = SQUISH;
               w_countNext = SQUISH_LOAD;
               w_blinkNext = 1'b1;
               w_stompNext = 1'b1;
            end
         end
         SQUISH: begin
            if (w_respawn) begin
               w_stateNext = ALIVE;
               w_countNext = 6'd0;
            end else if (w_frameTick) begin
               if (r_count == 6'd1) begin
                  w_stateNext = GONE;
                  w_countNext = 6'd0;
               end else if (r_count != 6'd0) begin
                  w_countNext = r_count - 6'd1;
                  if (r_count <= BLINK_LIM + 6'd1)
                     w_blinkNext = ~r_blink;
               end
            end
         end
         GONE: begin
            if (w_respawn) begin
               w_stateNext = ALIVE;
               w_countNext = 6'd0;
            end
         end
         default: begin
            w_stateNext = ALIVE;
            w_countNext = 6'd0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state      <= ALIVE;
         r_count      <= 6'd0;
         r_blink      <= 1'b0;
         r_stomp      <= 1'b0;
         r_fSync1     <= 1'b0;
         r_fSync2     <= 1'b0;
         r_fPrev      <= 1'b0;
         r_visD1      <= 1'b0;
         r_pixelValid <= 1'b0;
         r_colorIdx   <= 4'd0;
      end else begin
         r_state      <= w_stateNext;
         r_count      <= w_countNext;
         r_blink      <= w_blinkNext;
         r_stomp      <= w_stompNext;
         r_fSync1     <= frame_clk;
         r_fSync2     <= r_fSync1;
         r_fPrev      <= r_fSync2;
         r_visD1      <= is_enemy & w_visible;
         r_pixelValid <= r_visD1 & w_opaque;
         r_colorIdx   <= (r_visD1 && w_opaque) ? rom_data : 4'd0;
      end
   end

   assign enemy_pixel_valid = r_pixelValid;
   assign enemy_color_idx   = r_colorIdx;
   assign stomp_pulse       = r_stomp;
   assign enemy_state       = r_state;

endmodule

// File: tb/tb_enemy_pixel_pipe.sv
// Directed bench for enemy_pixel_pipe: pixel results go through an expected-value
// queue and are compared when they leave the two-stage pipeline.
module tb_enemy_pixel_pipe;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       frame_clk;
   logic       is_enemy;
   logic [8:0] enemy_address;
   logic       enemy_walk_count;
   logic       enemy_health;
   logic [9:0] rom_addr;
   logic [3:0] rom_data;
   logic       enemy_pixel_valid;
   logic [3:0] enemy_color_idx;
   logic       stomp_pulse;
   logic [1:0] enemy_state;

   int checks = 0;
   int errors = 0;
   logic [4:0] expQ[$];

   enemy_pixel_pipe #(.SQUISH_FRAMES(30), .BLINK_FRAMES(8)) dut (
      .Clk(Clk),
      .Reset(Reset),
      .frame_clk(frame_clk),
      .is_enemy(is_enemy),
      .enemy_address(enemy_address),
      .enemy_walk_count(enemy_walk_count),
      .enemy_health(enemy_health),
      .rom_addr(rom_addr),
      .rom_data(rom_data),
      .enemy_pixel_valid(enemy_pixel_valid),
      .enemy_color_idx(enemy_color_idx),
      .stomp_pulse(stomp_pulse),
      .enemy_state(enemy_state)
   );

   always #5 Clk = ~Clk;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One isolated pixel: address checked at once, result queued and checked two clocks later.
   task automatic applyStimulus(input bit en, input logic [8:0] addr, input bit walk, input bit hlth,
                                input logic [3:0] rdata, input bit expVis, input logic [9:0] expAddr,
                                input string tag);
      logic [4:0] exp;
      bit         v;
      @(negedge Clk);
      is_enemy = en; enemy_address = addr; enemy_walk_count = walk; enemy_health = hlth;
      #1 checkOutput({tag, "_addr"}, 16'(rom_addr), 16'(expAddr));
      v = en && expVis && (rdata != 4'd0);
      expQ.push_back({v, v ? rdata : 4'd0});
      @(negedge Clk);
      is_enemy = 1'b0; enemy_health = 1'b1; rom_data = rdata;
      @(negedge Clk);
      exp = expQ.pop_front();
      checkOutput({tag, "_valid"}, 16'(enemy_pixel_valid), 16'(exp[4]));
      checkOutput({tag, "_idx"}, 16'(enemy_color_idx), 16'(exp[3:0]));
      rom_data = 4'd0;
   endtask

   // frame_clk pulse long enough for the synchronizer; its tick is consumed on the third rising edge.
   task automatic frameTick();
      @(negedge Clk) frame_clk = 1'b1;
      repeat (3) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (3) @(negedge Clk);
   endtask

   logic [5:0] expCount;

   initial begin
      Reset = 1'b1; frame_clk = 1'b0; is_enemy = 1'b0; enemy_address = 9'd0;
      enemy_walk_count = 1'b0; enemy_health = 1'b1; rom_data = 4'd0;
      repeat (2) @(negedge Clk);
      checkOutput("rst_valid", 16'(enemy_pixel_valid), 16'd0);
      checkOutput("rst_idx", 16'(enemy_color_idx), 16'd0);
      checkOutput("rst_stomp", 16'(stomp_pulse), 16'd0);
      checkOutput("rst_state", 16'(enemy_state), 16'd0);
      Reset = 1'b0;

      applyStimulus(1, 9'h025, 1, 1, 4'd7, 1, 10'h125, "alive_a");
      applyStimulus(1, 9'h025, 1, 1, 4'd0, 1, 10'h125, "alive_transp");
      applyStimulus(1, 9'h1FF, 0, 1, 4'd3, 1, 10'h0FF, "alive_b");
      applyStimulus(0, 9'h025, 1, 1, 4'd7, 1, 10'h125, "not_enemy");

      @(negedge Clk);
      is_enemy = 1'b1; enemy_health = 1'b0; enemy_address = 9'h044;
      @(negedge Clk);
      checkOutput("stomp_pulse", 16'(stomp_pulse), 16'd1);
      checkOutput("stomp_state", 16'(enemy_state), 16'd1);
      checkOutput("stomp_addr", 16'(rom_addr), 16'h244);
      checkOutput("stomp_count", 16'(dut.r_count), 16'd30);
      @(negedge Clk);
      checkOutput("stomp_once", 16'(stomp_pulse), 16'd0);
      checkOutput("stomp_hold", 16'(enemy_state), 16'd1);
      is_enemy = 1'b0; enemy_health = 1'b1;

      applyStimulus(1, 9'h033, 0, 0, 4'd5, 1, 10'h233, "squish_30");
      for (int t = 1; t <= 30; t++) begin
         frameTick();
         expCount = 6'(30 - t);
         if (t < 30) begin
            checkOutput("squish_state", 16'(enemy_state), 16'd1);
            applyStimulus(1, 9'h033, 0, 0, 4'd5, (expCount > 6'd8) || expCount[0], 10'h233, "squish_px");
         end
      end
      checkOutput("gone_state", 16'(enemy_state), 16'd2);
      checkOutput("gone_count", 16'(dut.r_count), 16'd0);
      applyStimulus(1, 9'h033, 0, 0, 4'd5, 0, 10'h233, "gone_px");
      frameTick();
      checkOutput("gone_stays", 16'(enemy_state), 16'd2);

      @(negedge Clk);
      is_enemy = 1'b1; enemy_health = 1'b1; enemy_address = 9'h010; enemy_walk_count = 1'b0;
      @(negedge Clk);
      checkOutput("respawn_state", 16'(enemy_state), 16'd0);
      checkOutput("respawn_stomp", 16'(stomp_pulse), 16'd0);
      is_enemy = 1'b0;
      applyStimulus(1, 9'h010, 0, 1, 4'd9, 1, 10'h010, "respawn_a");
      applyStimulus(1, 9'h025, 1, 1, 4'd2, 1, 10'h125, "respawn_b");

      @(negedge Clk) frame_clk = 1'b1;
      repeat (2) @(negedge Clk);
      is_enemy = 1'b1; enemy_health = 1'b0;
      @(negedge Clk);
      checkOutput("coinc_stomp", 16'(stomp_pulse), 16'd1);
      checkOutput("coinc_state", 16'(enemy_state), 16'd1);
      checkOutput("coinc_count", 16'(dut.r_count), 16'd30);
      is_enemy = 1'b0; enemy_health = 1'b1; frame_clk = 1'b0;
      repeat (3) @(negedge Clk);

      @(negedge Clk) frame_clk = 1'b1;
      repeat (2) @(negedge Clk);
      is_enemy = 1'b1; enemy_health = 1'b1;
      @(negedge Clk);
      checkOutput("coinc_resp_state", 16'(enemy_state), 16'd0);
      checkOutput("coinc_resp_count", 16'(dut.r_count), 16'd0);
      checkOutput("coinc_resp_stomp", 16'(stomp_pulse), 16'd0);
      is_enemy = 1'b0; frame_clk = 1'b0;
      repeat (3) @(negedge Clk);

      @(negedge Clk);
      is_enemy = 1'b1; enemy_health = 1'b0;
      @(negedge Clk);
      is_enemy = 1'b0; enemy_health = 1'b1;
      repeat (18) frameTick();
      checkOutput("mid_count", 16'(dut.r_count), 16'd12);
      @(negedge Clk);
      is_enemy = 1'b1; enemy_health = 1'b0; rom_data = 4'd5;
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0; enemy_health = 1'b1;
      checkOutput("mid_rst_state", 16'(enemy_state), 16'd0);
      checkOutput("mid_rst_count", 16'(dut.r_count), 16'd0);
      checkOutput("mid_rst_valid1", 16'(enemy_pixel_valid), 16'd0);
      checkOutput("mid_rst_idx1", 16'(enemy_color_idx), 16'd0);
      checkOutput("mid_rst_stomp", 16'(stomp_pulse), 16'd0);
      @(negedge Clk);
      checkOutput("mid_rst_valid2", 16'(enemy_pixel_valid), 16'd0);
      checkOutput("mid_rst_idx2", 16'(enemy_color_idx), 16'd0);
      @(negedge Clk);
      checkOutput("mid_rst_resume", 16'(enemy_color_idx), 16'd5);
      is_enemy = 1'b0; rom_data = 4'd0;
      repeat (2) @(negedge Clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/enemy_pixel_pipe.md
Name: enemy_pixel_pipe

Overview:
Downstream consumer of the enemy controller's per-pixel outputs (is_enemy, enemy_address, enemy_walk_count, enemy_health). It fetches the enemy sprite from a synchronous sprite ROM and delivers a pipelined, transparency-aware palette index to the color mapper. It also runs the enemy death sequence: alive, then a squished sprite held for a fixed number of frames with a blinking tail, then invisible, with a one-cycle stomp pulse for scoring.

Parameters:
SQUISH_FRAMES, 30, frames the squished sprite is shown before the enemy disappears (1..63).
BLINK_FRAMES, 8, final frames of the squish period during which the sprite blinks (must be < SQUISH_FRAMES).

Ports:
Clk  in  1  system clock; the only clock.
Reset  in  1  synchronous, active-high reset.
frame_clk  in  1  vertical-sync-rate frame strobe (level signal); sampled in the Clk domain.
is_enemy  in  1  current DrawX/DrawY pixel lies inside the enemy box.
enemy_address  in  9  pixel offset within sprite; bits [7:0] = row*16+col, bit 8 ignored.
enemy_walk_count  in  1  walk animation frame select (0 = frame A, 1 = frame B).
enemy_health  in  1  1 = alive; meaningful only while is_enemy = 1 (forced 0 otherwise upstream).
rom_addr  out  10  sprite ROM address {frame_sel[1:0], enemy_address[7:0]}; combinational.
rom_data  in  4  sprite ROM palette index, valid one Clk after rom_addr.
enemy_pixel_valid  out  1  registered; 1 = draw enemy_color_idx at this pixel.
enemy_color_idx  out  4  registered palette index; 0 whenever enemy_pixel_valid = 0.
stomp_pulse  out  1  one-Clk pulse on the ALIVE->SQUISH transition.
enemy_state  out  2  00 ALIVE, 01 SQUISH, 10 GONE (debug/score logic).

Behaviour:
- Reset: state = ALIVE, squish counter = 0, blink phase = 0, frame_clk synchronizer and edge detector = 0, pipeline valid bits = 0. All registered outputs are 0 and enemy_state = 00.
- frame_clk passes through a 2-flop synchronizer. frame_tick is a one-Clk pulse on the rising edge of the synchronized signal.
- frame_sel:
  - ALIVE: {1'b0, enemy_walk_count}.
  - SQUISH/GONE: 2'b10 (squished sprite).
  - Code 2'b11 is never issued.
- Pipeline, latency 2 Clk. Inputs at cycle N drive rom_addr at N. rom_data arrives at N+1. Outputs are registered at N+2.
  - Stage-1 register captures vis = is_enemy AND visible, where visible is evaluated at cycle N.
  - enemy_pixel_valid(N+2) = vis_d1 AND (rom_data != 0). Palette index 0 is transparent.
  - enemy_color_idx = rom_data when valid, else 0.
- visible:
  - ALIVE: 1.
  - GONE: 0.
  - SQUISH: 1 when counter > BLINK_FRAMES; otherwise equals blink phase, which toggles on every frame_tick while counter <= BLINK_FRAMES. Blink phase is cleared to 1 on entry to SQUISH.
- State machine (health is sampled only when is_enemy = 1):
  - ALIVE -> SQUISH: is_enemy=1 and enemy_health=0. Load counter = SQUISH_FRAMES and assert stomp_pulse for exactly 1 Clk. Further pixels in the same frame do not retrigger the transition.
  - SQUISH: counter decrements by 1 on each frame_tick. When frame_tick occurs with counter = 1, go to GONE and set the counter to 0.
  - SQUISH or GONE -> ALIVE: is_enemy=1 and enemy_health=1 (respawn or level reload). Counter is cleared and no stomp_pulse is generated.
  - is_enemy=0 never changes state.
- Simultaneous events:
  - Respawn takes priority over frame_tick decrement.
  - If frame_tick coincides with the ALIVE->SQUISH transition, the counter loads SQUISH_FRAMES with no decrement that cycle.
- Counter is 6 bits. It never wraps: a decrement at 0 is blocked.
- Reset asserted mid-squish returns the block to ALIVE on the next Clk. The pipeline flushes, and outputs are 0 on the following cycle.

Test Plan:
- Reset then ALIVE pixel stream: walk_count=1, enemy_address=0x25, is_enemy=1 -> rom_addr=0x125. rom_data=7 at N+1 gives enemy_pixel_valid=1 and enemy_color_idx=7 at N+2. Same pixel with rom_data=0 gives valid=0 and idx=0.
- Stomp: is_enemy=1, enemy_health=0 on consecutive pixels -> stomp_pulse high for exactly 1 Clk, enemy_state=01, rom_addr upper bits = 10, counter=30.
- Squish timing with SQUISH_FRAMES=30, BLINK_FRAMES=8:
  - Sprite is solid for 22 frame_ticks.
  - It then alternates invisible/visible on frames 8..1.
  - enemy_state=10 after the 30th tick, and pixel_valid stays 0 thereafter even with rom_data=5.
- Respawn: in GONE, apply is_enemy=1, enemy_health=1 -> enemy_state=00 next Clk, no stomp_pulse, walk frames resume.
- Coincident events:
  - frame_tick on the same Clk as the stomp -> counter=30, not 29.
  - Respawn on the same Clk as a frame_tick during SQUISH -> ALIVE.
- Reset mid-SQUISH (counter=12): assert Reset 1 Clk -> enemy_state=00, counter=0, and all outputs 0 for the next 2 Clk.
